// File: rtl/store_merge_unit.sv
// ============================================================================
// Module      : store_merge_unit
// Description : Narrows SW/SH/SB store data and writes it to a word-only
//               memory port, using read-modify-write for sub-word stores.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module store_merge_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    output logic              busy,
    output logic              done,
    output logic              misalign,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [1:0] C_OP_SW = 2'b00;
    localparam logic [1:0] C_OP_SH = 2'b01;
    localparam logic [1:0] C_OP_SB = 2'b10;

    state_t            r_state_q, w_state_d;
    logic [1:0]        r_op_q,    w_op_d;
    logic [1:0]        r_lane_q,  w_lane_d;
    logic [31:0]       r_data_q,  w_data_d;
    logic [31:0]       r_wdata_q, w_wdata_d;
    logic [ADDR_W-1:0] r_addr_q,  w_addr_d;
    logic              r_mis_q,   w_mis_d;

    logic              w_accept;
    logic              w_req_mis;
    logic [31:0]       w_merged;

    assign w_accept = req_valid && req_ready;

    // Reserved op is rejected alongside genuinely misaligned addresses.
    always_comb begin
        w_req_mis = 1'b0;
        case (req_op)
            C_OP_SW: w_req_mis = (req_addr[1:0] != 2'b00);
            C_OP_SH: w_req_mis = req_addr[0];
            C_OP_SB: w_req_mis = 1'b0;
            default: w_req_mis = 1'b1;
        endcase
    end

    // Lane merge of the registered store data into the word just read.
    always_comb begin
        w_merged = mem_rdata;
        case (r_op_q)
            C_OP_SH: begin
                if (r_lane_q[1]) w_merged = {r_data_q[15:0], mem_rdata[15:0]};
                else             w_merged = {mem_rdata[31:16], r_data_q[15:0]};
            end
            C_OP_SB: begin
                case (r_lane_q)
                    2'd0:    w_merged = {mem_rdata[31:8], r_data_q[7:0]};
                    2'd1:    w_merged = {mem_rdata[31:16], r_data_q[7:0], mem_rdata[7:0]};
                    2'd2:    w_merged = {mem_rdata[31:24], r_data_q[7:0], mem_rdata[15:0]};
                    default: w_merged = {r_data_q[7:0], mem_rdata[23:0]};
                endcase
            end
            default: w_merged = r_data_q;
        endcase
    end

    always_comb begin
        w_state_d = r_state_q;
        w_op_d    = r_op_q;
        w_lane_d  = r_lane_q;
        w_data_d  = r_data_q;
        w_wdata_d = r_wdata_q;
        w_addr_d  = r_addr_q;
        w_mis_d   = r_mis_q;
        case (r_state_q)
            S_IDLE: begin
                if (w_accept) begin
                    w_op_d   = req_op;
                    w_lane_d = req_addr[1:0];
                    w_data_d = req_data;
                    w_addr_d = {req_addr[ADDR_W-1:2], 2'b00};
                    w_mis_d  = w_req_mis;
                    if (w_req_mis) begin
                        w_state_d = S_RESP;
                    end else if (req_op == C_OP_SW) begin
                        w_wdata_d = req_data;
                        w_state_d = S_WR;
                    end else begin
                        w_state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                if (mem_ack) begin
                    w_wdata_d = w_merged;
                    w_state_d = S_WR;
                end
            end
            S_WR: begin
                if (mem_ack) w_state_d = S_RESP;
            end
            default: begin
                w_mis_d   = 1'b0;
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= S_IDLE;
            r_op_q    <= 2'b00;
            r_lane_q  <= 2'b00;
            r_data_q  <= 32'd0;
            r_wdata_q <= 32'd0;
            r_addr_q  <= '0;
            r_mis_q   <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_op_q    <= w_op_d;
            r_lane_q  <= w_lane_d;
            r_data_q  <= w_data_d;
            r_wdata_q <= w_wdata_d;
            r_addr_q  <= w_addr_d;
            r_mis_q   <= w_mis_d;
        end
    end

    assign req_ready = !rst && (r_state_q == S_IDLE);
    assign busy      = (r_state_q != S_IDLE);
    assign done      = (r_state_q == S_RESP);
    assign misalign  = (r_state_q == S_RESP) && r_mis_q;
    assign mem_rd    = (r_state_q == S_RD);
    assign mem_wr    = (r_state_q == S_WR);
    assign mem_addr  = r_addr_q;
    assign mem_wdata = r_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_store_merge_unit.sv
// ============================================================================
// Module      : tb_store_merge_unit
// Description : Self-checking bench; a timeline/memory model predicts every
//               output cycle by cycle for directed and random stores.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_store_merge_unit;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_data;
    logic              busy, done, misalign;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd, mem_wr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem [logic [31:0]];

    store_merge_unit #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .busy      (busy),
        .done      (done),
        .misalign  (misalign),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_get(input logic [31:0] wa);
        if (!mem.exists(wa)) mem[wa] = $urandom;
        return mem[wa];
    endfunction

    // Runs one store from an idle sample point and checks every cycle until
    // done, then returns at the sample point of the following idle cycle.
    task automatic run(input logic [1:0] op, input logic [31:0] addr,
                       input logic [31:0] data, input int rd_w, input int wr_w);
        logic        mis, need_rd;
        logic [31:0] wa, old, m, exp_w;
        int          sh, rd_len, wr_len, done_cyc;
        bit          in_rd, in_wr, resp;

        mis     = (op == 2'd3) || (op == 2'd0 && addr[1:0] != 2'b00) || (op == 2'd1 && addr[0]);
        wa      = addr & 32'hFFFF_FFFC;
        need_rd = !mis && (op != 2'd0);
        old     = need_rd ? mem_get(wa) : 32'd0;
        m       = (op == 2'd0) ? 32'hFFFF_FFFF : (op == 2'd1) ? 32'h0000_FFFF : 32'h0000_00FF;
        sh      = (op == 2'd0) ? 0 : (op == 2'd1) ? 16 * int'(addr[1]) : 8 * int'(addr[1:0]);
        exp_w   = (old & ~(m << sh)) | ((data & m) << sh);
        rd_len  = need_rd ? rd_w + 1 : 0;
        wr_len  = mis ? 0 : wr_w + 1;
        done_cyc = 1 + rd_len + wr_len;

        chk("idle_ready", {31'd0, req_ready}, 32'd1);
        chk("idle_busy",  {31'd0, busy}, 32'd0);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_data  = data;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_op    = 2'($urandom);
        req_addr  = $urandom;
        req_data  = $urandom;

        for (int k = 1; k <= done_cyc; k++) begin
            in_rd = (k <= rd_len);
            in_wr = !in_rd && (k <= rd_len + wr_len);
            resp  = (k == done_cyc);
            chk("mem_rd",    {31'd0, mem_rd},    {31'd0, in_rd});
            chk("mem_wr",    {31'd0, mem_wr},    {31'd0, in_wr});
            chk("done",      {31'd0, done},      {31'd0, resp});
            chk("misalign",  {31'd0, misalign},  {31'd0, resp && mis});
            chk("req_ready", {31'd0, req_ready}, 32'd0);
            chk("busy",      {31'd0, busy},      32'd1);
            if (in_rd || in_wr) chk("mem_addr", mem_addr, wa);
            if (in_wr)          chk("mem_wdata", mem_wdata, exp_w);
            mem_rdata = $urandom;
            if (in_rd && k == rd_len) begin
                mem_ack   = 1'b1;
                mem_rdata = old;
            end else if (in_wr && k == rd_len + wr_len) begin
                mem_ack = 1'b1;
                mem[wa] = mem_wdata;
            end else begin
                mem_ack = resp ? 1'($urandom) : 1'b0;
            end
            if (!resp) begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        chk("post_done", {31'd0, done}, 32'd0);
        mem_ack = 1'($urandom);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 2'd0;
        req_addr  = '0;
        req_data  = 32'd0;
        mem_rdata = 32'd0;
        mem_ack   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready",  {31'd0, req_ready}, 32'd0);
        chk("rst_ctrl",   {27'd0, busy, done, misalign, mem_rd, mem_wr}, 32'd0);
        chk("rst_addr",   mem_addr, 32'd0);
        chk("rst_wdata",  mem_wdata, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_rel_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;

        run(2'd0, 32'h100, 32'hDEADBEEF, 0, 0);
        chk("lit_sw", mem[32'h100], 32'hDEADBEEF);

        mem[32'h200] = 32'h11223344;
        run(2'd2, 32'h203, 32'h000000AA, 0, 0);
        chk("lit_sb", mem[32'h200], 32'hAA223344);

        mem[32'h200] = 32'h11223344;
        run(2'd1, 32'h202, 32'h0000BEEF, 3, 3);
        chk("lit_sh", mem[32'h200], 32'hBEEF3344);

        mem_ack = 1'b1;
        run(2'd1, 32'h101, 32'h12345678, 0, 0);
        run(2'd0, 32'h102, 32'h12345678, 0, 0);
        run(2'd3, 32'h104, 32'h12345678, 0, 0);
        mem_ack = 1'b0;

        // Reset while an SB read is outstanding.
        req_valid = 1'b1; req_op = 2'd2; req_addr = 32'h301; req_data = 32'h55;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rrd_mem_rd", {31'd0, mem_rd}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rrd_ctrl", {27'd0, busy, done, misalign, mem_rd, mem_wr}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rrd_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        run(2'd0, 32'h400, 32'hCAFEF00D, 1, 2);
        chk("lit_sw2", mem[32'h400], 32'hCAFEF00D);

        mem[32'h300] = 32'h00000000;
        run(2'd2, 32'h300, 32'h11, 0, 0);
        run(2'd2, 32'h301, 32'h22, 0, 0);
        run(2'd2, 32'h302, 32'h33, 0, 0);
        run(2'd2, 32'h303, 32'h44, 0, 0);
        chk("lit_b2b", mem[32'h300], 32'h44332211);

        for (int i = 0; i < 80; i++) begin
            run(2'($urandom), 32'h500 + $urandom_range(0, 31), $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/store_merge_unit.md
Name: store_merge_unit

Overview:
- Store-side counterpart to the load-path extenders.
- Accepts SW/SH/SB requests from the MEM stage and narrows register data to byte or halfword width.
- Writes to the word-only data cache/DDR port: SW as a single write; SH/SB as read-modify-write (read word, merge lane, write word).
- Detects misaligned stores and reports them without touching memory.

Parameters:
ADDR_W, 32, byte-address width of req_addr and mem_addr

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req_valid  in  1  store request present
req_ready  out  1  unit idle; request accepted when req_valid && req_ready
req_op  in  2  00=SW, 01=SH, 10=SB, 11=reserved
req_addr  in  ADDR_W  byte address
req_data  in  32  register data; low 16/8 bits used for SH/SB
busy  out  1  request in flight (state != IDLE)
done  out  1  one-cycle completion pulse
misalign  out  1  qualifies done: request rejected, no memory access
mem_addr  out  ADDR_W  word address, {addr[ADDR_W-1:2],2'b00}
mem_rd  out  1  read request, held until mem_ack
mem_wr  out  1  write request, held until mem_ack
mem_wdata  out  32  write word
mem_rdata  in  32  read word, valid in the mem_ack cycle
mem_ack  in  1  one-cycle acknowledge for the current mem_rd/mem_wr

Behaviour:
- Interface: one clock (clk), synchronous active-high reset (rst). All state updates on the rising edge of clk.
- Reset: state=IDLE. req_ready=1 (0 while rst is asserted). busy, done, misalign, mem_rd, mem_wr=0. mem_addr and mem_wdata=0.
- Accept: at acceptance, req_op, req_addr and req_data are registered. Inputs may change afterwards without effect.
- Byte order: little-endian. Byte lane = addr[1:0]; halfword lane = addr[1].
- FSM states: IDLE, RD, WR, RESP.
- IDLE on accept:
  - SW with addr[1:0]=00 -> WR, mem_wdata=req_data.
  - SH with addr[0]=0 -> RD.
  - SB (any address) -> RD.
  - SW with addr[1:0]!=00, SH with addr[0]=1, or op=11 -> RESP with misalign latched to 1.
- RD: mem_rd=1, mem_addr=word address. On mem_ack, merge into mem_wdata, then -> WR:
  - SH lane0: {rdata[31:16], data[15:0]}.
  - SH lane1: {data[15:0], rdata[15:0]}.
  - SB lane k: rdata with bits [8k+7:8k] replaced by data[7:0].
- WR: mem_wr=1, mem_wdata stable. On mem_ack -> RESP.
- RESP: done=1 for exactly one cycle. misalign=1 only for a rejected request, else 0. Then -> IDLE.
- Signal relationships: mem_rd and mem_wr are never asserted together. req_ready=1 only in IDLE. busy = !req_ready outside reset.
- mem_ack outside RD/WR is ignored.
- Wait states: unbounded. The unit holds mem_rd/mem_wr and mem_addr stable until mem_ack.
- Latency, counted from the accept edge with zero wait states:
  - SW: done 2 cycles after accept.
  - SH/SB: done 3 cycles after accept.
  - Misaligned: done 1 cycle after accept.
- Back-to-back: a new request can be accepted in the cycle after done. No overlap.
- Reset mid-operation: any state -> IDLE on the next edge. mem_rd/mem_wr drop. No done pulse. A partial RMW write is abandoned; a write acked in the same edge as rst counts as performed, but no done is issued.

Test Plan:
- Reset, then SW addr=0x100, data=0xDEADBEEF, ack after 0 waits -> one mem_wr to 0x100 with wdata 0xDEADBEEF; done at cycle+2; misalign=0; mem_rd never asserted.
- SB addr=0x203, data=0x000000AA, memory word 0x11223344 -> mem_rd to 0x200, then mem_wr 0xAA223344; done at cycle+3.
- SH addr=0x202, data=0x0000BEEF, memory 0x11223344, 3 wait states on each access -> mem_wdata=0xBEEF3344; mem_rd/mem_wr held 4 cycles each; mem_addr=0x200 throughout.
- Misaligned SH addr=0x101, SW addr=0x102 and op=11 -> each gives done=misalign=1 one cycle after accept, no mem_rd/mem_wr; spurious mem_ack in IDLE ignored.
- rst asserted during RD of an SB -> next cycle state IDLE, mem_rd=0, no done, req_ready=1. Following SW completes normally.
- Back-to-back SB lanes 0..3 to 0x300 over 0x00000000 with data 0x11,0x22,0x33,0x44 -> final write 0x44332211; each accepted the cycle after the previous done.
